// File: rtl/osd_ctm_pkg.sv
// Shared types and constants for the CTM event scheduler: packet type codes,
// flag bit positions and the buffered trace event record.
package osd_ctm_pkg;

    localparam int unsigned MAX_ADDR_WIDTH = 64;
    localparam int unsigned MAX_TIME_WIDTH = 64;

    localparam logic [1:0] EV_TYPE  = 2'b01;
    localparam logic [1:0] OVF_TYPE = 2'b10;

    localparam int unsigned FLG_CSR      = 0;
    localparam int unsigned FLG_BR_TAKEN = 1;
    localparam int unsigned FLG_JAL      = 2;
    localparam int unsigned FLG_JALR     = 3;
    localparam int unsigned FLG_TRAP     = 4;
    localparam int unsigned FLG_XCPT     = 5;
    localparam int unsigned NUM_FLAGS    = 6;

    // Fields are sized for the widest supported build; narrower builds zero-extend.
    typedef struct packed {
        logic [MAX_ADDR_WIDTH-1:0] pc;
        logic [MAX_ADDR_WIDTH-1:0] npc;
        logic [MAX_TIME_WIDTH-1:0] timestamp;
        logic [1:0]                prv;
        logic [NUM_FLAGS-1:0]      flags;
    } trace_event_t;

    function automatic logic [15:0] word16(input logic [63:0] v, input logic [1:0] idx);
        return v[{idx, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/osd_ctm_event_sched_if.sv
// DII flit link: valid/last/data from the scheduler, ready back from the interconnect.
interface osd_ctm_event_sched_if;

    logic        valid;
    logic        last;
    logic [15:0] data;
    logic        ready;

    modport master (output valid, output last, output data, input ready);
    modport slave  (input valid, input last, input data, output ready);

endinterface

// File: rtl/osd_ctm_event_fifo.sv
// Synchronous FIFO of trace events; caller must not push when full unless popping.
module osd_ctm_event_fifo
    import osd_ctm_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  trace_event_t wdata,
    input  logic         pop,
    output trace_event_t head,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(FIFO_DEPTH);

    trace_event_t  mem [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_pop;

    assign full   = (count_q == DEPTH_CNT);
    assign empty  = (count_q == '0);
    assign head   = mem[rptr_q];
    assign do_pop = pop & ~empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/osd_ctm_event_sched.sv
// CTM event scheduler: filters retired-instruction events, buffers them and emits DII
// trace packets. Define OSD_CTM_OVERFLOW_PKT_EN to report dropped events in overflow packets.
module osd_ctm_event_sched
    import osd_ctm_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned TIME_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9:0]            id,
    input  logic [9:0]            cfg_dest,
    input  logic                  cfg_enable,
    input  logic [5:0]            cfg_mask,
    input  logic                  trace_valid,
    input  logic [ADDR_WIDTH-1:0] trace_pc,
    input  logic [ADDR_WIDTH-1:0] trace_npc,
    input  logic                  trace_jal,
    input  logic                  trace_jalr,
    input  logic                  trace_branch,
    input  logic                  trace_br_taken,
    input  logic                  trace_trap,
    input  logic                  trace_xcpt,
    input  logic                  trace_csr,
    input  logic [1:0]            trace_prv,
    input  logic [TIME_WIDTH-1:0] trace_time,
    osd_ctm_event_sched_if.master debug_out,
    output logic                  busy
);

    localparam logic [1:0] AW_LAST = 2'(ADDR_WIDTH / 16 - 1);
    localparam logic [1:0] TW_LAST = 2'(TIME_WIDTH / 16 - 1);

`ifdef OSD_CTM_OVERFLOW_PKT_EN
    typedef enum logic [2:0] {
        StIdle, StDest, StSrc, StType, StPc, StNpc, StTime, StOvfCnt
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StDest, StSrc, StType, StPc, StNpc, StTime
    } state_e;
`endif

    state_e       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [9:0]   dest_q, id_q;
    logic         start;

    logic [NUM_FLAGS-1:0] flags;
    logic         capture;
    trace_event_t ev;
    trace_event_t head;
    logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic         accept;

`ifdef OSD_CTM_OVERFLOW_PKT_EN
    logic         ovf_sel_q;
    logic [15:0]  ovf_val_q;
    logic [15:0]  ovf_cnt_q, ovf_cnt_d;
    logic         ovf_start;
    logic         drop;
`endif

    always_comb begin
        flags               = '0;
        flags[FLG_CSR]      = trace_csr;
        flags[FLG_BR_TAKEN] = trace_branch & trace_br_taken;
        flags[FLG_JAL]      = trace_jal;
        flags[FLG_JALR]     = trace_jalr;
        flags[FLG_TRAP]     = trace_trap;
        flags[FLG_XCPT]     = trace_xcpt;
    end

    always_comb begin
        ev                             = '0;
        ev.pc[ADDR_WIDTH-1:0]          = trace_pc;
        ev.npc[ADDR_WIDTH-1:0]         = trace_npc;
        ev.timestamp[TIME_WIDTH-1:0]   = trace_time;
        ev.prv                         = trace_prv;
        ev.flags                       = flags;
    end

    assign capture   = trace_valid & cfg_enable & (|(flags & cfg_mask));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign fifo_push = capture & (~fifo_full | fifo_pop);
    assign accept    = debug_out.ready;

    osd_ctm_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (ev),
        .pop   (fifo_pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        start    = 1'b0;
        fifo_pop = 1'b0;
`ifdef OSD_CTM_OVERFLOW_PKT_EN
        ovf_start = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef OSD_CTM_OVERFLOW_PKT_EN
                if (ovf_cnt_q != '0) begin
                    state_d   = StDest;
                    start     = 1'b1;
                    ovf_start = 1'b1;
                end else
`endif
                if (!fifo_empty) begin
                    state_d = StDest;
                    start   = 1'b1;
                end
            end
            StDest: if (accept) state_d = StSrc;
            StSrc:  if (accept) state_d = StType;
            StType: begin
                if (accept) begin
                    cnt_d   = '0;
                    state_d = StPc;
`ifdef OSD_CTM_OVERFLOW_PKT_EN
                    if (ovf_sel_q) state_d = StOvfCnt;
`endif
                end
            end
            StPc: begin
                if (accept) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == AW_LAST) begin
                        cnt_d   = '0;
                        state_d = StNpc;
                    end
                end
            end
            StNpc: begin
                if (accept) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == AW_LAST) begin
                        cnt_d   = '0;
                        state_d = StTime;
                    end
                end
            end
            StTime: begin
                if (accept) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == TW_LAST) begin
                        cnt_d    = '0;
                        fifo_pop = 1'b1;
                        state_d  = StIdle;
                    end
                end
            end
`ifdef OSD_CTM_OVERFLOW_PKT_EN
            StOvfCnt: if (accept) state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase
    end

`ifdef OSD_CTM_OVERFLOW_PKT_EN
    assign drop = capture & ~fifo_push;

    // Clear happens first so a drop coinciding with the sample leaves a count of one.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_start) begin
            ovf_cnt_d = '0;
        end
        if (drop && ovf_cnt_d != 16'hFFFF) begin
            ovf_cnt_d = ovf_cnt_d + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            dest_q    <= '0;
            id_q      <= '0;
`ifdef OSD_CTM_OVERFLOW_PKT_EN
            ovf_sel_q <= 1'b0;
            ovf_val_q <= '0;
            ovf_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start) begin
                dest_q <= cfg_dest;
                id_q   <= id;
`ifdef OSD_CTM_OVERFLOW_PKT_EN
                ovf_sel_q <= ovf_start;
                ovf_val_q <= ovf_cnt_q;
`endif
            end
`ifdef OSD_CTM_OVERFLOW_PKT_EN
            ovf_cnt_q <= ovf_cnt_d;
`endif
        end
    end

    always_comb begin
        debug_out.valid = (state_q != StIdle);
        debug_out.last  = 1'b0;
        debug_out.data  = '0;
        unique case (state_q)
            StIdle: ;
            StDest: debug_out.data = {6'b0, dest_q};
            StSrc:  debug_out.data = {6'b0, id_q};
            StType: begin
                debug_out.data = {EV_TYPE, 6'b0, head.prv, head.flags};
`ifdef OSD_CTM_OVERFLOW_PKT_EN
                if (ovf_sel_q) debug_out.data = {OVF_TYPE, 14'b0};
`endif
            end
            StPc:   debug_out.data = word16(head.pc, cnt_q);
            StNpc:  debug_out.data = word16(head.npc, cnt_q);
            StTime: begin
                debug_out.data = word16(head.timestamp, cnt_q);
                debug_out.last = (cnt_q == TW_LAST);
            end
`ifdef OSD_CTM_OVERFLOW_PKT_EN
            StOvfCnt: begin
                debug_out.data = ovf_val_q;
                debug_out.last = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign busy = (state_q != StIdle) | ~fifo_empty;

endmodule

// File: tb/tb_osd_ctm_event_sched.sv
// Self-checking bench for osd_ctm_event_sched: directed cases plus a randomized stream
// compared against a packet-level model.
module tb_osd_ctm_event_sched;

    localparam int unsigned ADDR_WIDTH = 64;
    localparam int unsigned TIME_WIDTH = 64;
    localparam int unsigned FIFO_DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [9:0]            id = '0;
    logic [9:0]            cfg_dest = '0;
    logic                  cfg_enable = 1'b0;
    logic [5:0]            cfg_mask = '0;
    logic                  trace_valid = 1'b0;
    logic [ADDR_WIDTH-1:0] trace_pc = '0;
    logic [ADDR_WIDTH-1:0] trace_npc = '0;
    logic                  trace_jal = 1'b0, trace_jalr = 1'b0, trace_branch = 1'b0;
    logic                  trace_br_taken = 1'b0, trace_trap = 1'b0, trace_xcpt = 1'b0;
    logic                  trace_csr = 1'b0;
    logic [1:0]            trace_prv = '0;
    logic [TIME_WIDTH-1:0] trace_time = '0;
    logic                  busy;

    osd_ctm_event_sched_if dbg ();

    osd_ctm_event_sched #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .TIME_WIDTH (TIME_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id             (id),
        .cfg_dest       (cfg_dest),
        .cfg_enable     (cfg_enable),
        .cfg_mask       (cfg_mask),
        .trace_valid    (trace_valid),
        .trace_pc       (trace_pc),
        .trace_npc      (trace_npc),
        .trace_jal      (trace_jal),
        .trace_jalr     (trace_jalr),
        .trace_branch   (trace_branch),
        .trace_br_taken (trace_br_taken),
        .trace_trap     (trace_trap),
        .trace_xcpt     (trace_xcpt),
        .trace_csr      (trace_csr),
        .trace_prv      (trace_prv),
        .trace_time     (trace_time),
        .debug_out      (dbg),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] got_data[$];
    bit          got_last[$];
    logic [15:0] exp_data[$];
    bit          exp_last[$];
    int          completed = 0;
    int          captured = 0;

    // Flits accepted at the next rising edge are recorded on the falling edge before it.
    always @(negedge clk) begin
        if (rst && dbg.valid && dbg.ready) begin
            got_data.push_back(dbg.data);
            got_last.push_back(dbg.last);
            if (dbg.last) completed++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] d, input bit l);
        exp_data.push_back(d);
        exp_last.push_back(l);
    endtask

    task automatic expect_event(input logic [63:0] pc, input logic [63:0] npc,
                                input logic [63:0] tm, input logic [1:0] prv,
                                input logic [5:0] f);
        push_exp({6'b0, cfg_dest}, 1'b0);
        push_exp({6'b0, id}, 1'b0);
        push_exp({2'b01, 6'b0, prv, f}, 1'b0);
        for (int i = 0; i < ADDR_WIDTH / 16; i++) push_exp(pc[i*16 +: 16], 1'b0);
        for (int i = 0; i < ADDR_WIDTH / 16; i++) push_exp(npc[i*16 +: 16], 1'b0);
        for (int i = 0; i < TIME_WIDTH / 16; i++)
            push_exp(tm[i*16 +: 16], i == TIME_WIDTH / 16 - 1);
    endtask

    task automatic expect_ovf(input logic [15:0] cnt);
        push_exp({6'b0, cfg_dest}, 1'b0);
        push_exp({6'b0, id}, 1'b0);
        push_exp(16'h8000, 1'b0);
        push_exp(cnt, 1'b1);
    endtask

    function automatic logic [5:0] flag_vec(input logic [6:0] cls);
        // cls = {xcpt, trap, jalr, jal, branch, br_taken, csr}
        return {cls[6], cls[5], cls[4], cls[3], cls[2] & cls[1], cls[0]};
    endfunction

    task automatic set_trace(input logic [63:0] pc, input logic [63:0] npc,
                             input logic [63:0] tm, input logic [1:0] prv,
                             input logic [6:0] cls);
        trace_pc       = pc;
        trace_npc      = npc;
        trace_time     = tm;
        trace_prv      = prv;
        {trace_xcpt, trace_trap, trace_jalr, trace_jal,
         trace_branch, trace_br_taken, trace_csr} = cls;
        trace_valid    = 1'b1;
    endtask

    // Reference: an event becomes a packet when enabled and any selected flag is set.
    task automatic model_event(input logic [63:0] pc, input logic [63:0] npc,
                               input logic [63:0] tm, input logic [1:0] prv,
                               input logic [6:0] cls);
        logic [5:0] f;
        f = flag_vec(cls);
        if (cfg_enable && |(f & cfg_mask)) begin
            expect_event(pc, npc, tm, prv, f);
            captured++;
        end
    endtask

    task automatic wait_drain(input string tag);
        int idle_cyc = 0;
        int n = 0;
        while (idle_cyc < 3 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            idle_cyc = (dbg.valid || busy) ? 0 : idle_cyc + 1;
        end
        if (n >= 3000) chk({tag, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        chk({tag, "_flit_count"}, 64'(got_data.size()), 64'(exp_data.size()));
        n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data[%0d]", tag, i), 64'(got_data[i]), 64'(exp_data[i]));
            chk($sformatf("%s_last[%0d]", tag, i), 64'(got_last[i]), 64'(exp_last[i]));
        end
        got_data.delete();
        got_last.delete();
        exp_data.delete();
        exp_last.delete();
    endtask

    initial begin
        logic [63:0] pc, npc, tm;
        logic [1:0]  prv;
        logic [6:0]  cls;
        logic [15:0] hold_d;
        bit          hold_l;
        bit          saw_busy;
        int          n;
        int          ev_count;

        dbg.ready = 1'b0;
        #12;
        chk("reset_valid", 64'(dbg.valid), 64'd0);
        chk("reset_last", 64'(dbg.last), 64'd0);
        chk("reset_data", 64'(dbg.data), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single jal event with fixed fields and latency check.
        cfg_dest   = 10'h005;
        id         = 10'h012;
        cfg_enable = 1'b1;
        cfg_mask   = 6'b000100;
        dbg.ready  = 1'b1;
        set_trace(64'h8000_0000, 64'h8000_0010, 64'h1234, 2'd3, 7'b0001000);
        model_event(64'h8000_0000, 64'h8000_0010, 64'h1234, 2'd3, 7'b0001000);
        @(posedge clk);
        #1;
        trace_valid = 1'b0;
        chk("latency_valid_k", 64'(dbg.valid), 64'd0);
        @(posedge clk);
        #1;
        chk("latency_valid_k1", 64'(dbg.valid), 64'd1);
        chk("latency_dest", 64'(dbg.data), 64'h0005);
        wait_drain("jal");
        compare_stream("jal");

        // Masked-out flag and disabled capture produce nothing.
        saw_busy = 1'b0;
        cfg_mask = 6'b111110;
        set_trace(64'h100, 64'h104, 64'h55, 2'd0, 7'b0000001);
        model_event(64'h100, 64'h104, 64'h55, 2'd0, 7'b0000001);
        @(posedge clk);
        #1;
        trace_valid = 1'b0;
        cfg_enable  = 1'b0;
        cfg_mask    = 6'b111111;
        set_trace(64'h200, 64'h204, 64'h66, 2'd1, 7'b0001000);
        model_event(64'h200, 64'h204, 64'h66, 2'd1, 7'b0001000);
        @(posedge clk);
        #1;
        trace_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (busy || dbg.valid) saw_busy = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("filtered_busy", 64'(saw_busy), 64'd0);
        compare_stream("filtered");

        // Stall mid-PC; dest/id changes during the packet must not leak in.
        cfg_enable = 1'b1;
        pc  = {$urandom, $urandom};
        npc = {$urandom, $urandom};
        tm  = {$urandom, $urandom};
        set_trace(pc, npc, tm, 2'd2, 7'b1000000);
        model_event(pc, npc, tm, 2'd2, 7'b1000000);
        @(posedge clk);
        #1;
        trace_valid = 1'b0;
        n = 0;
        while (got_data.size() < 4 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("stall_reach_timeout", 64'd1, 64'd0);
        dbg.ready = 1'b0;
        cfg_dest  = 10'h3AA;
        id        = 10'h155;
        hold_d    = dbg.data;
        hold_l    = dbg.last;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 64'(dbg.valid), 64'd1);
            chk("stall_data", 64'(dbg.data), 64'(hold_d));
            chk("stall_last", 64'(dbg.last), 64'(hold_l));
        end
        chk("stall_busy", 64'(busy), 64'd1);
        dbg.ready = 1'b1;
        wait_drain("stall");
        compare_stream("stall");

        // Seven back-to-back events with the sink stalled: the first occupies the
        // FIFO in flight, three more fill it, the remaining three are dropped.
        cfg_dest  = 10'h005;
        id        = 10'h012;
        dbg.ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            pc  = 64'h1000 + 64'(i) * 4;
            npc = pc + 4;
            tm  = 64'h9000 + 64'(i);
            set_trace(pc, npc, tm, 2'd1, 7'b0001000);
            if (i == 0) expect_event(pc, npc, tm, 2'd1, 6'b000100);
`ifdef OSD_CTM_OVERFLOW_PKT_EN
            if (i == 1) expect_ovf(16'd3);
`endif
            if (i >= 1 && i <= 3) expect_event(pc, npc, tm, 2'd1, 6'b000100);
            @(posedge clk);
            #1;
        end
        trace_valid = 1'b0;
        chk("overflow_stalled_busy", 64'(busy), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        dbg.ready = 1'b1;
        wait_drain("overflow");
        compare_stream("overflow");

        // Reset mid-packet truncates immediately; a fresh event then goes out whole.
        set_trace(64'hABCD, 64'hABD1, 64'h77, 2'd0, 7'b0010000);
        @(posedge clk);
        #1;
        trace_valid = 1'b0;
        n = 0;
        while (got_data.size() < 6 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("reset_reach_timeout", 64'd1, 64'd0);
        rst = 1'b0;
        #1;
        chk("midrst_valid", 64'(dbg.valid), 64'd0);
        chk("midrst_last", 64'(dbg.last), 64'd0);
        chk("midrst_data", 64'(dbg.data), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        got_data.delete();
        got_last.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        pc  = {$urandom, $urandom};
        npc = {$urandom, $urandom};
        tm  = {$urandom, $urandom};
        set_trace(pc, npc, tm, 2'd3, 7'b0100000);
        model_event(pc, npc, tm, 2'd3, 7'b0100000);
        @(posedge clk);
        #1;
        trace_valid = 1'b0;
        wait_drain("after_reset");
        compare_stream("after_reset");

        // Randomized stream: random flags, mask, enable and backpressure.
        completed = 0;
        captured  = 0;
        ev_count  = 0;
        cfg_dest  = 10'($urandom);
        id        = 10'($urandom);
        for (int cyc = 0; cyc < 4000 && ev_count < 40; cyc++) begin
            dbg.ready   = ($urandom_range(3) != 0);
            trace_valid = 1'b0;
            if ((captured - completed) < FIFO_DEPTH && $urandom_range(1) == 0) begin
                pc         = {$urandom, $urandom};
                npc        = {$urandom, $urandom};
                tm         = {$urandom, $urandom};
                prv        = 2'($urandom);
                cls        = 7'($urandom);
                cfg_mask   = 6'($urandom);
                cfg_enable = ($urandom_range(9) != 0);
                set_trace(pc, npc, tm, prv, cls);
                model_event(pc, npc, tm, prv, cls);
                ev_count++;
            end
            @(posedge clk);
            #1;
        end
        trace_valid = 1'b0;
        dbg.ready   = 1'b1;
        wait_drain("random");
        compare_stream("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
